// File: rtl/ov7670_pkg.sv
// ov7670_pkg -- shared definitions for the OV7670 capture block.
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default active frame size (640 x 480)
//   WIN_W_DEF / WIN_H_DEF       : default crop window size (256 x 256)
//   PIX_W                       : RGB565 pixel width
//   cap_state_e                 : capture FSM states
package ov7670_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int WIN_W_DEF    = 256;
    localparam int WIN_H_DEF    = 256;
    localparam int PIX_W        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        FRAME = 2'd2
    } cap_state_e;

endpackage

// File: rtl/cam_byte_pack.sv
// cam_byte_pack -- pairs camera bytes into RGB565 pixels.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   byte_en_i     : a camera byte is present on data_i this cycle
//   flush_i       : discard any half-pair and return to "first byte" phase
//   keep_i        : the pair completing this cycle is in range and is emitted
//   data_i        : camera byte
//   pair_stb_o    : a pair completes this cycle (combinational, before keep)
//   odd_o         : a first byte is held waiting for its partner
//   p_valid_o     : one-cycle registered pixel pulse
//   p_data_o      : registered pixel, first byte in the upper half
module cam_byte_pack
    import ov7670_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             byte_en_i,
    input  logic             flush_i,
    input  logic             keep_i,
    input  logic [7:0]       data_i,
    output logic             pair_stb_o,
    output logic             odd_o,
    output logic             p_valid_o,
    output logic [PIX_W-1:0] p_data_o
);

    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic             vld_q, vld_d;
    logic [PIX_W-1:0] pd_q, pd_d;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        vld_d   = 1'b0;
        pd_d    = pd_q;
        if (flush_i) begin
            phase_d = 1'b0;
        end else if (byte_en_i) begin
            if (!phase_q) begin
                hi_d    = data_i;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (keep_i) begin
                    vld_d = 1'b1;
                    pd_d  = {hi_q, data_i};
                end
            end
        end
    end

    assign pair_stb_o = byte_en_i & phase_q & ~flush_i;
    assign odd_o      = phase_q;
    assign p_valid_o  = vld_q;
    assign p_data_o   = pd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
            vld_q   <= 1'b0;
            pd_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            vld_q   <= vld_d;
            pd_q    <= pd_d;
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture -- OV7670 RGB565 capture with crop-window buffer writes.
// Ports:
//   cam_pclk, rst           : camera pixel clock, synchronous active-high reset
//   cam_vsync/href/data     : camera sync and byte bus
//   capture_en              : 0 freezes the buffer (sampled at frame start)
//   p_valid/p_data/p_x/p_y  : assembled pixel stream with coordinates
//   f_done                  : one-cycle end-of-frame pulse
//   wr_en/wr_addr/wr_data   : crop-window buffer write port
//   line_err                : sticky line-length error
// Build option: OV7670_CAPTURE_LINE_CHECK_EN enables the line-length check;
// without it line_err is constant 0.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int WIN_W    = WIN_W_DEF,
    parameter int WIN_H    = WIN_H_DEF
) (
    input  logic             cam_pclk,
    input  logic             rst,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    input  logic             capture_en,
    output logic             p_valid,
    output logic [PIX_W-1:0] p_data,
    output logic [9:0]       p_x,
    output logic [8:0]       p_y,
    output logic             f_done,
    output logic             wr_en,
    output logic [15:0]      wr_addr,
    output logic [PIX_W-1:0] wr_data,
    output logic             line_err
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);
    localparam logic [9:0] W_LIM = 10'(WIN_W);
    localparam logic [8:0] WH_LIM = 9'(WIN_H);

    cap_state_e  state_q, state_d;
    logic        href_q;
    logic        frame_en_q, frame_en_d;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic [9:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic        fdone_q, fdone_d;
    logic        wen_q, wen_d;
    logic [15:0] waddr_q, waddr_d;

    logic frame_start, frame_end, href_fall, byte_en, keep;
    logic pair_stb, odd;

    // IDLE only leaves on a vsync high, so a frame already running at
    // startup or after reset is never captured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cam_vsync)  state_d = BLANK;
            BLANK:   if (!cam_vsync) state_d = FRAME;
            FRAME:   if (cam_vsync)  state_d = BLANK;
            default: state_d = IDLE;
        endcase
    end

    assign frame_start = (state_q == BLANK) && !cam_vsync;
    assign frame_end   = (state_q == FRAME) && cam_vsync;
    assign byte_en     = (state_q == FRAME) && !cam_vsync && cam_href;
    assign href_fall   = (state_q == FRAME) && href_q && !cam_href;
    assign keep        = (col_q < H_LIM) && (row_q < V_LIM);

    cam_byte_pack u_pack (
        .clk_i      (cam_pclk),
        .rst_i      (rst),
        .byte_en_i  (byte_en),
        .flush_i    (href_fall | frame_end),
        .keep_i     (keep),
        .data_i     (cam_data),
        .pair_stb_o (pair_stb),
        .odd_o      (odd),
        .p_valid_o  (p_valid),
        .p_data_o   (p_data)
    );

    // col_q stops at H_ACTIVE and row_q at V_ACTIVE: past those limits
    // nothing is emitted, so neither counter can wrap inside a frame.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        px_d       = px_q;
        py_d       = py_q;
        fdone_d    = 1'b0;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        frame_en_d = frame_en_q;
        if (frame_start) frame_en_d = capture_en;
        if (frame_end) begin
            col_d   = '0;
            row_d   = '0;
            px_d    = '0;
            py_d    = '0;
            fdone_d = 1'b1;
        end else if (href_fall) begin
            col_d = '0;
            px_d  = '0;
            if (col_q != 10'd0 && row_q < V_LIM) row_d = row_q + 9'd1;
        end else if (pair_stb && keep) begin
            col_d   = col_q + 10'd1;
            px_d    = col_q;
            py_d    = row_q;
            wen_d   = frame_en_q && (col_q < W_LIM) && (row_q < WH_LIM);
            waddr_d = {row_q[7:0], col_q[7:0]};
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            state_q    <= IDLE;
            href_q     <= 1'b0;
            frame_en_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            px_q       <= '0;
            py_q       <= '0;
            fdone_q    <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            href_q     <= cam_href;
            frame_en_q <= frame_en_d;
            col_q      <= col_d;
            row_q      <= row_d;
            px_q       <= px_d;
            py_q       <= py_d;
            fdone_q    <= fdone_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
        end
    end

    assign p_x     = px_q;
    assign p_y     = py_q;
    assign f_done  = fdone_q;
    assign wr_en   = wen_q;
    assign wr_addr = waddr_q;
    assign wr_data = p_data;

`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    // Counts every completed pair, including ones dropped past H_ACTIVE,
    // so an over-long line is flagged even though it emits H_ACTIVE pixels.
    logic [10:0] pairs_q, pairs_d;
    logic        lerr_q, lerr_d;

    always_comb begin
        pairs_d = pairs_q;
        lerr_d  = lerr_q;
        if (frame_end) begin
            pairs_d = '0;
        end else if (href_fall) begin
            pairs_d = '0;
            if (odd || pairs_q != 11'(H_ACTIVE)) lerr_d = 1'b1;
        end else if (pair_stb && pairs_q != 11'h7FF) begin
            pairs_d = pairs_q + 11'd1;
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            pairs_q <= '0;
            lerr_q  <= 1'b0;
        end else begin
            pairs_q <= pairs_d;
            lerr_q  <= lerr_d;
        end
    end

    assign line_err = lerr_q;
`else
    logic unused_odd;
    assign unused_odd = odd;
    assign line_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
module tb_ov7670_capture;

    localparam int H = 20;
    localparam int V = 10;
    localparam int WW = 8;
    localparam int WH = 6;

    logic        cam_pclk = 1'b0;
    logic        rst = 1'b1;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        capture_en = 1'b1;
    logic        p_valid, f_done, wr_en, line_err;
    logic [15:0] p_data, wr_addr, wr_data;
    logic [9:0]  p_x;
    logic [8:0]  p_y;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .WIN_W(WW), .WIN_H(WH)) dut (
        .cam_pclk   (cam_pclk),
        .rst        (rst),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .capture_en (capture_en),
        .p_valid    (p_valid),
        .p_data     (p_data),
        .p_x        (p_x),
        .p_y        (p_y),
        .f_done     (f_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .line_err   (line_err)
    );

    always #5 cam_pclk = ~cam_pclk;

    // Event monitor, sampling away from the active edge.
    int          n_pv = 0, n_we = 0, n_fd = 0;
    int          max_px = 0, max_py = 0;
    logic [15:0] last_addr = 16'h0, last_wdata = 16'h0, first_addr = 16'hDEAD;
    logic        arm = 1'b0, got_first = 1'b0;

    always @(negedge cam_pclk) begin
        if (p_valid) begin
            n_pv++;
            if (int'(p_x) > max_px) max_px = int'(p_x);
            if (int'(p_y) > max_py) max_py = int'(p_y);
        end
        if (wr_en) begin
            n_we++;
            last_addr  = wr_addr;
            last_wdata = wr_data;
            if (arm && !got_first) begin
                got_first  = 1'b1;
                first_addr = wr_addr;
            end
        end
        if (f_done) n_fd++;
    end

    int nt = 0, nf = 0;
    int s_pv, s_we, s_fd;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    localparam logic EXP_LERR = 1'b1;
`else
    localparam logic EXP_LERR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nt++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge cam_pclk);
    endtask

    task automatic snap();
        s_pv = n_pv;
        s_we = n_we;
        s_fd = n_fd;
    endtask

    // Pixel k of line y is {y, k}; bytes before 'from' are assumed sent.
    task automatic send_bytes(input int y, input int from, input int n);
        for (int j = from; j < n; j++) begin
            cam_data = (j % 2 == 0) ? 8'(y) : 8'(j / 2);
            cam_href = 1'b1;
            @(negedge cam_pclk);
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        tick(4);
    endtask

    task automatic lines(input int from, input int to);
        for (int y = from; y < to; y++) send_bytes(y, 0, 2 * H);
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        tick(3);
        cam_vsync = 1'b0;
        tick(3);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        tick(4);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_p_valid", 32'(p_valid), 0);
        chk("rst_f_done", 32'(f_done), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_line_err", 32'(line_err), 0);
        chk("rst_p_data", 32'(p_data), 0);
        chk("rst_p_xy", {p_x, 7'd0, p_y, 6'd0}, 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);

        // Startup mid-frame: reset released with vsync low and href active
        cam_href = 1'b1;
        rst = 1'b0;
        snap();
        for (int i = 0; i < 40; i++) begin
            cam_data = 8'(i * 7);
            @(negedge cam_pclk);
        end
        cam_href = 1'b0;
        tick(4);
        chk("startup_no_pvalid", 32'(n_pv - s_pv), 0);
        chk("startup_no_fdone", 32'(n_fd - s_fd), 0);

        // Nominal frame with byte-order check on the first pixel
        snap();
        frame_start();
        cam_data = 8'hF8;
        cam_href = 1'b1;
        @(negedge cam_pclk);
        chk("order_no_early_valid", 32'(p_valid), 0);
        cam_data = 8'h1F;
        @(negedge cam_pclk);
        chk("order_p_valid", 32'(p_valid), 1);
        chk("order_p_data", 32'(p_data), 32'hF81F);
        chk("order_p_x", 32'(p_x), 0);
        chk("order_p_y", 32'(p_y), 0);
        chk("order_wr_en", 32'(wr_en), 1);
        chk("order_wr_addr", 32'(wr_addr), 0);
        send_bytes(0, 2, 2 * H);
        lines(1, V);
        frame_end();
        chk("nom_pvalid_cnt", 32'(n_pv - s_pv), 32'(H * V));
        chk("nom_wren_cnt", 32'(n_we - s_we), 32'(WW * WH));
        chk("nom_last_addr", 32'(last_addr), 32'h0507);
        chk("nom_last_wdata", 32'(last_wdata), 32'h0507);
        chk("nom_fdone_cnt", 32'(n_fd - s_fd), 1);
        chk("nom_max_py", 32'(max_py), 32'(V - 1));
        chk("nom_xy_clear", {22'd0, p_x} | {23'd0, p_y}, 0);
        chk("nom_line_err", 32'(line_err), 0);

        // Freeze: capture_en drops mid-frame, current frame still written
        snap();
        frame_start();
        lines(0, 3);
        capture_en = 1'b0;
        lines(3, V);
        frame_end();
        chk("frz_cur_wren", 32'(n_we - s_we), 32'(WW * WH));
        chk("frz_cur_fdone", 32'(n_fd - s_fd), 1);
        snap();
        frame_start();
        lines(0, V);
        frame_end();
        chk("frz_next_wren", 32'(n_we - s_we), 0);
        chk("frz_next_pvalid", 32'(n_pv - s_pv), 32'(H * V));
        chk("frz_next_fdone", 32'(n_fd - s_fd), 1);
        capture_en = 1'b1;

        // Boundaries: long line, odd line
        snap();
        frame_start();
        send_bytes(0, 0, 2 * H + 2);
        send_bytes(1, 0, 2 * H + 1);
        lines(2, V);
        frame_end();
        chk("bnd_pvalid_cnt", 32'(n_pv - s_pv), 32'(H * V));
        chk("bnd_max_px", 32'(max_px), 32'(H - 1));
        chk("bnd_wren_cnt", 32'(n_we - s_we), 32'(WW * WH));
        chk("bnd_realign_wdata", 32'(last_wdata), 32'h0507);
        chk("bnd_line_err", 32'(line_err), 32'(EXP_LERR));

        // Reset mid-frame at line 4 (inside the write window)
        frame_start();
        lines(0, 4);
        for (int j = 0; j < 10; j++) begin
            cam_data = 8'(j);
            cam_href = 1'b1;
            @(negedge cam_pclk);
        end
        rst = 1'b1;
        tick(2);
        snap();
        chk("mid_rst_line_err", 32'(line_err), 0);
        rst = 1'b0;
        send_bytes(4, 10, 2 * H);
        lines(5, V);
        frame_end();
        chk("mid_rst_no_fdone", 32'(n_fd - s_fd), 0);
        chk("mid_rst_no_wren", 32'(n_we - s_we), 0);
        chk("mid_rst_no_pvalid", 32'(n_pv - s_pv), 0);
        snap();
        arm = 1'b1;
        frame_start();
        lines(0, V);
        frame_end();
        chk("post_rst_got_write", 32'(got_first), 1);
        chk("post_rst_first_addr", 32'(first_addr), 0);
        chk("post_rst_wren_cnt", 32'(n_we - s_we), 32'(WW * WH));
        chk("post_rst_fdone", 32'(n_fd - s_fd), 1);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
